// File: rtl/trng_word_collector.sv
// TRNG word collector: four-phase bit handshake, optional von Neumann debias,
// WIDTH-bit word assembly and a DEPTH-entry show-ahead output FIFO.

// Generic show-ahead FIFO with a combinational head.
// Latency: a push is visible at the head the cycle after it is accepted.
// Backpressure: in_rdy_o is low only when full with no same-cycle pop.
module trng_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_vld_i,
   output logic                   in_rdy_o,
   input  logic [WIDTH-1:0]       in_dat_i,
   output logic                   out_vld_o,
   input  logic                   out_rdy_i,
   output logic [WIDTH-1:0]       out_dat_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             empty;
   logic             full;
   logic             wr_en;
   logic             rd_en;

   // A pop frees its slot for a push in the same cycle, so a full FIFO can
   // still accept when the consumer is taking the head.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == FULL_CNT);
      rd_en    = out_rdy_i && !empty;
      in_rdy_o = !full || rd_en;
      wr_en    = in_vld_i && in_rdy_o;
   end

   assign out_vld_o = !empty;
   assign out_dat_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Storage, power-of-two pointers that wrap naturally, and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= in_dat_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (wr_en && !rd_en) begin
            count_q <= count_q + 1'b1;
         end else if (!wr_en && rd_en) begin
            count_q <= count_q - 1'b1;
         end
      end
   end
endmodule

// Collects TRNG bits via four-phase req/ack into words, pushes them to a FIFO.
// Latency: ack 3 cycles after pin READY edge; word at head 1 cycle after last capture.
// Backpressure: full FIFO parks a finished word in HOLD with the source disabled.
module trng_word_collector #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int DEBIAS = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   continuous_i,
   output logic                   trng_en_o,
   input  logic                   trng_bit_i,
   input  logic                   trng_ready_i,
   output logic                   trng_ack_o,
   output logic [WIDTH-1:0]       word_o,
   output logic                   word_valid_o,
   input  logic                   word_ready_i,
   output logic [$clog2(DEPTH):0] fifo_count_o,
   output logic                   busy_o
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam logic [$clog2(DEPTH):0] FIFO_FULL = DEPTH[$clog2(DEPTH):0];

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t           state_q;
   logic             ready_s1_q;
   logic             ready_s2_q;
   logic             bit_s1_q;
   logic             bit_s2_q;
   logic             ack_q;
   logic             trng_en_q;
   logic             busy_q;
   logic             cont_q;
   logic             pair_vld_q;
   logic             pair_bit_q;
   logic [CW-1:0]    bit_cnt_q;
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;

   logic             capture;
   logic             yield_vld;
   logic             yield_bit;
   logic             word_last;
   logic             push_vld;
   logic             fifo_in_rdy;
   logic             fifo_full;
   logic [$clog2(DEPTH):0] fifo_count;

   // Capture, debias and word-assembly decisions, all from synchronised inputs.
   // A pair yields its first bit when the two bits differ (01 -> 0, 10 -> 1).
   always_comb begin
      capture   = (state_q == ST_COLLECT) && ready_s2_q && !ack_q && !stop_i;
      yield_vld = capture;
      yield_bit = bit_s2_q;
      if (DEBIAS != 0) begin
         yield_vld = capture && pair_vld_q && (pair_bit_q != bit_s2_q);
         yield_bit = pair_bit_q;
      end
      word_d = word_q;
      if (yield_vld) begin
         word_d[bit_cnt_q] = yield_bit;
      end
      word_last = yield_vld && (bit_cnt_q == LAST_IDX);
      fifo_full = (fifo_count == FIFO_FULL);
      // A word finishing in COLLECT may use a slot freed by a same-cycle pop;
      // a held word waits until the registered occupancy shows a free slot.
      push_vld  = (word_last && fifo_in_rdy) ||
                  ((state_q == ST_HOLD) && !stop_i && !fifo_full);
   end

   // Synchronisers, four-phase acknowledge, debias pair and the control FSM.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         ready_s1_q <= 1'b0;
         ready_s2_q <= 1'b0;
         bit_s1_q   <= 1'b0;
         bit_s2_q   <= 1'b0;
         ack_q      <= 1'b0;
         trng_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         cont_q     <= 1'b0;
         pair_vld_q <= 1'b0;
         pair_bit_q <= 1'b0;
         bit_cnt_q  <= '0;
         word_q     <= '0;
      end else begin
         ready_s1_q <= trng_ready_i;
         ready_s2_q <= ready_s1_q;
         bit_s1_q   <= trng_bit_i;
         bit_s2_q   <= bit_s1_q;

         // ACK returns low independently of state so a STOP never strands
         // the source mid-handshake.
         if (ack_q && !ready_s2_q) begin
            ack_q <= 1'b0;
         end else if (capture) begin
            ack_q <= 1'b1;
         end

         if (capture && (DEBIAS != 0)) begin
            if (!pair_vld_q) begin
               pair_vld_q <= 1'b1;
               pair_bit_q <= bit_s2_q;
            end else begin
               pair_vld_q <= 1'b0;
            end
         end

         if (yield_vld) begin
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (start_i && !stop_i) begin
                  state_q   <= ST_COLLECT;
                  cont_q    <= continuous_i;
                  bit_cnt_q <= '0;
                  trng_en_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            ST_COLLECT: begin
               if (stop_i) begin
                  state_q    <= ST_IDLE;
                  trng_en_q  <= 1'b0;
                  busy_q     <= 1'b0;
                  pair_vld_q <= 1'b0;
               end else if (word_last) begin
                  bit_cnt_q <= '0;
                  if (!fifo_in_rdy) begin
                     state_q   <= ST_HOLD;
                     trng_en_q <= 1'b0;
                  end else if (!cont_q) begin
                     state_q    <= ST_IDLE;
                     trng_en_q  <= 1'b0;
                     busy_q     <= 1'b0;
                     pair_vld_q <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (stop_i) begin
                  state_q    <= ST_IDLE;
                  trng_en_q  <= 1'b0;
                  busy_q     <= 1'b0;
                  pair_vld_q <= 1'b0;
               end else if (!fifo_full) begin
                  bit_cnt_q <= '0;
                  if (cont_q) begin
                     state_q   <= ST_COLLECT;
                     trng_en_q <= 1'b1;
                  end else begin
                     state_q    <= ST_IDLE;
                     busy_q     <= 1'b0;
                     pair_vld_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               trng_en_q  <= 1'b0;
               busy_q     <= 1'b0;
               pair_vld_q <= 1'b0;
            end
         endcase
      end
   end

   trng_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .in_vld_i  (push_vld),
      .in_rdy_o  (fifo_in_rdy),
      .in_dat_i  (word_d),
      .out_vld_o (word_valid_o),
      .out_rdy_i (word_ready_i),
      .out_dat_o (word_o),
      .count_o   (fifo_count)
   );

   assign fifo_count_o = fifo_count;
   assign trng_en_o    = trng_en_q;
   assign trng_ack_o   = ack_q;
   assign busy_o       = busy_q;
endmodule
